seq_bin_to_bcd: RTL and testbench



---
 rtl/seq_bin_to_bcd.sv | 119 +++++++++++
 tb/tb_seq_bin_to_bcd.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin_to_bcd.sv
// Sequential shift-and-add-3 (double-dabble) binary to BCD converter.
// Converts the magnitude of a signed or unsigned input and reports the sign separately.
module seq_bin_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] mag_reg, mag_next;
    logic [SW-1:0]    scratch_reg, scratch_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             sign_reg, sign_next;
    logic [SW-1:0]    bcd_reg, bcd_next;
    logic             neg_reg, neg_next;

    logic [SW-1:0]    scratch_adj;
    logic [SW-1:0]    scratch_shift;
    logic [WIDTH-1:0] mag_in;

    // Per-digit add-3 correction applied before every shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                          ? scratch_reg[4*gi +: 4] + 4'd3
                                          : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // The top bit of the adjusted scratch is always zero when DIGITS is sized correctly.
    assign scratch_shift = SW'({scratch_adj, mag_reg[WIDTH-1]});

    // Two's-complement negation wraps -2^(WIDTH-1) onto its own unsigned magnitude.
    assign mag_in = (signed_mode && bin_in[WIDTH-1])
                  ? (~bin_in + {{(WIDTH-1){1'b0}}, 1'b1})
                  : bin_in;

    always_comb begin
        state_next   = state_reg;
        mag_next     = mag_reg;
        scratch_next = scratch_reg;
        count_next   = count_reg;
        sign_next    = sign_reg;
        bcd_next     = bcd_reg;
        neg_next     = neg_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mag_next     = mag_in;
                    sign_next    = signed_mode & bin_in[WIDTH-1];
                    scratch_next = '0;
                    count_next   = CW'(WIDTH);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = scratch_shift;
                mag_next     = {mag_reg[WIDTH-2:0], 1'b0};
                count_next   = count_reg - 1'b1;
                if (count_reg == CW'(1)) begin
                    // Publish on entry to DONE so the result is visible alongside the pulse.
                    bcd_next   = scratch_shift;
                    neg_next   = sign_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mag_reg     <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            sign_reg    <= 1'b0;
            bcd_reg     <= '0;
            neg_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mag_reg     <= mag_next;
            scratch_reg <= scratch_next;
            count_reg   <= count_next;
            sign_reg    <= sign_next;
            bcd_reg     <= bcd_next;
            neg_reg     <= neg_next;
        end
    end

    assign bcd_out = bcd_reg;
    assign neg     = neg_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd: vector table, scoreboard monitor,
// hand-written busy/reset corner sequences and a full sweep against a decimal model.
module tb_seq_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [7:0]  bin_in;
    logic [11:0] bcd_out;
    logic        neg;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
    } exp_t;

    typedef struct {
        logic        sm;
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        neg;
    } vec_t;

    exp_t        sb[$];
    logic        mon_on = 1'b0;
    logic [11:0] hold_bcd = '0;
    logic        hold_neg = 1'b0;
    vec_t        tbl[10];

    seq_bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .bin_in      (bin_in),
        .bcd_out     (bcd_out),
        .neg         (neg),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Decimal reference built from integer division, independent of the shift algorithm.
    function automatic exp_t ref_model(input logic sm, input logic [7:0] b);
        int   v;
        exp_t r;
        v     = (sm && b[7]) ? 256 - int'(b) : int'(b);
        r.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        r.neg = sm && b[7];
        return r;
    endfunction

    // Results are consumed when done is seen; between pulses the outputs must not move.
    always @(negedge clk) begin : monitor
        exp_t me;
        if (mon_on) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    me = sb.pop_front();
                    chk("bcd_out", 32'(bcd_out), 32'(me.bcd));
                    chk("neg", 32'(neg), 32'(me.neg));
                end
                hold_bcd = bcd_out;
                hold_neg = neg;
            end else begin
                chk("hold_bcd", 32'(bcd_out), 32'(hold_bcd));
                chk("hold_neg", 32'(neg), 32'(hold_neg));
            end
        end
    end

    // Entered and left at posedge+1; the start cycle is the current one.
    task automatic conv(input logic sm, input logic [7:0] b, input exp_t e);
        int n;
        sb.push_back(e);
        start       = 1'b1;
        signed_mode = sm;
        bin_in      = b;
        @(posedge clk); #1;
        start       = 1'b0;
        bin_in      = 8'($urandom);
        signed_mode = 1'($urandom);
        n = 1;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(10));
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        exp_t e;

        tbl[0] = '{1'b0, 8'hFF, 12'h255, 1'b0};
        tbl[1] = '{1'b1, 8'h80, 12'h128, 1'b1};
        tbl[2] = '{1'b1, 8'hFF, 12'h001, 1'b1};
        tbl[3] = '{1'b1, 8'h7F, 12'h127, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 12'h000, 1'b0};
        tbl[5] = '{1'b0, 8'h63, 12'h099, 1'b0};
        tbl[6] = '{1'b0, 8'h64, 12'h100, 1'b0};
        tbl[7] = '{1'b1, 8'h00, 12'h000, 1'b0};
        tbl[8] = '{1'b1, 8'h9C, 12'h100, 1'b1};
        tbl[9] = '{1'b1, 8'hF6, 12'h010, 1'b1};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold_bcd = '0; hold_neg = 1'b0;
        mon_on = 1'b1;
        chk("reset_bcd", 32'(bcd_out), 32'(0));
        chk("reset_neg", 32'(neg), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));

        // Unsigned max with cycle-accurate busy/done profile.
        e.bcd = 12'h255; e.neg = 1'b0;
        sb.push_back(e);
        start = 1'b1; signed_mode = 1'b0; bin_in = 8'hFF;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'((c <= 9) ? 1 : 0));
            chk($sformatf("done_c%0d", c), 32'(done), 32'((c == 9) ? 1 : 0));
        end
        chk("sb_empty_max", 32'(sb.size()), 32'(0));

        for (int i = 0; i < 10; i++) begin
            e.bcd = tbl[i].bcd;
            e.neg = tbl[i].neg;
            conv(tbl[i].sm, tbl[i].bin, e);
        end

        // Starts during SHIFT and in the DONE cycle are ignored.
        e.bcd = 12'h010; e.neg = 1'b0;
        sb.push_back(e);
        start = 1'b1; signed_mode = 1'b0; bin_in = 8'h0A;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start  = (c == 4 || c == 9);
            bin_in = 8'h14;
            if (c == 9) chk("busy_seq_done", 32'(done), 32'(1));
        end
        @(posedge clk); #1;
        chk("busy_seq_one_result", 32'(sb.size()), 32'(0));
        conv(1'b0, 8'h14, ref_model(1'b0, 8'h14));
        chk("busy_seq_second", 32'(bcd_out), 32'(12'h020));

        // Reset in the middle of a conversion aborts it and clears the outputs.
        start = 1'b1; signed_mode = 1'b0; bin_in = 8'hC8;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        hold_bcd = '0; hold_neg = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_bcd", 32'(bcd_out), 32'(0));
        repeat (12) begin
            @(posedge clk); #1;
        end
        conv(1'b0, 8'hC8, ref_model(1'b0, 8'hC8));
        chk("abort_retry", 32'(bcd_out), 32'(12'h200));

        // Reset and start together: reset wins.
        rst = 1'b1; start = 1'b1; signed_mode = 1'b1; bin_in = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        hold_bcd = '0; hold_neg = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'(0));
        chk("rst_start_bcd", 32'(bcd_out), 32'(0));
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("rst_start_idle", 32'(busy), 32'(0));

        // Exhaustive sweep, back-to-back.
        for (int sm = 0; sm < 2; sm++) begin
            for (int b = 0; b < 256; b++) begin
                conv(1'(sm), 8'(b), ref_model(1'(sm), 8'(b)));
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("sb_empty_end", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
